spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter DataWidth, default 8, bits per SPI frame, transferred MSB first.
REQ-002 SHALL have parameter SyncStages, default 2, flops in each input synchroniser; legal values are 2 or more.
REQ-003 SHALL have port clk_sys_i  input  1  system clock, the single clock of the block.
REQ-004 SHALL have port rst_sys_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port spi_cs_ni  input  1  chip select from the controller, active-low, asynchronous to clk_sys_i.
REQ-006 SHALL have port spi_sck_i  input  1  SPI clock from the controller, asynchronous to clk_sys_i.
REQ-007 SHALL have port spi_copi_i  input  1  controller-out/peripheral-in data.
REQ-008 SHALL have port spi_cipo_o  output  1  peripheral-out/controller-in data.
REQ-009 SHALL have port spi_cipo_en_o  output  1  output enable for spi_cipo_o.
REQ-010 SHALL have port tx_data_i  input  DataWidth  next byte to send.
REQ-011 SHALL have port tx_valid_i  input  1  tx_data_i valid.
REQ-012 SHALL have port tx_ready_o  output  1  TX holding register empty.
REQ-013 SHALL have port rx_data_o  output  DataWidth  last received byte.
REQ-014 SHALL have port rx_valid_o  output  1  rx_data_o valid.
REQ-015 SHALL have port rx_ready_i  input  1  consumer accepts rx_data_o.
REQ-016 SHALL have port overrun_o  output  1  one-cycle pulse: received byte dropped.
REQ-017 SHALL have port underrun_o  output  1  one-cycle pulse: frame started with TX holding empty.
REQ-018 SHALL have port busy_o  output  1  high while in ACTIVE state.

Function
REQ-019 SHALL support SPI mode 0 only: sample COPI on SCK rise, change CIPO on SCK fall; SCK frequency SHALL be at most clk_sys_i/8.
REQ-020 SHALL pass spi_cs_ni, spi_sck_i and spi_copi_i through SyncStages-flop synchronisers; each of cs fall, cs rise, sck rise and sck fall SHALL be a one-cycle event, detected by comparing the last synchroniser stage with one further registered copy.
REQ-021 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on a cs-fall event; ACTIVE->IDLE on a cs-rise event.
REQ-022 SHALL, in ACTIVE, hold bit counter 0..DataWidth-1 and RX and TX shift registers, all DataWidth bits wide.
REQ-023 SHALL perform a TX byte load on the cs-fall event and on the first sck-fall event after a byte completes:
- if the TX holding register is full, move it into the TX shift register and mark it empty;
- if it is empty, load all-zeros and pulse underrun_o.
REQ-024 SHALL drive spi_cipo_o from TX shift register MSB and spi_cipo_en_o = busy_o; spi_cipo_o SHALL be 0 in IDLE.
REQ-025 SHALL, on each sck-rise event, shift the synchronised COPI into the RX shift register LSB and increment the bit counter.
REQ-026 SHALL, on each sck-fall event that does not trigger a byte load, shift the TX shift register left by one.
REQ-027 SHALL complete a byte on the sck-rise event when the counter is DataWidth-1, wrapping the counter to 0.
REQ-028 SHALL write the completed byte, including the final bit, to rx_data_o and set rx_valid_o on the next clk_sys_i cycle; total latency is SyncStages+1 cycles from the first clk_sys_i edge that samples SCK high.
REQ-029 SHALL keep rx_valid_o high until rx_valid_o && rx_ready_i; it SHALL clear on the following cycle.
REQ-030 SHALL, on byte completion while rx_valid_o=1 and rx_ready_i=0, drop the new byte, keep rx_data_o unchanged and pulse overrun_o for 1 cycle.
REQ-031 SHALL treat completion in the same cycle as handshake acceptance as no overrun: the new byte is written and rx_valid_o stays 1.
REQ-032 SHALL set tx_ready_o = holding empty and accept on tx_valid_i && tx_ready_o; holding SHALL be writable in IDLE or ACTIVE.
REQ-033 SHALL, when a TX accept and a TX byte load coincide with the holding register empty, load zeros and pulse underrun_o; the accepted byte is kept for the next load.
REQ-034 SHALL, on a cs-rise event mid-byte, discard the partial RX byte with no rx_valid_o; the TX byte already loaded is lost and the holding register is unaffected.
REQ-035 SHALL ignore sck events while in IDLE.

Reset
REQ-036 SHALL, with rst_sys_i high at a clk_sys_i edge, set: state IDLE; counter, shift registers, rx_data_o and holding all zero; rx_valid_o, overrun_o, underrun_o, busy_o, spi_cipo_o and spi_cipo_en_o at 0; tx_ready_o at 1.
REQ-037 SHALL preload synchronisers to the idle bus levels (cs=1, sck=0) so release from reset produces no spurious event.
REQ-038 SHALL treat reset asserted mid-frame as abort; after release, the block SHALL wait for a fresh cs-fall event.

Verification
REQ-039 Write TX 0xA5, assert CS, clock 8 bits of COPI 0x3C at clk/8 -> CIPO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C, rx_valid_o high SyncStages+1 cycles after the 8th SCK rise.
REQ-040 Send two bytes 0x11, 0x22 with rx_ready_i=0 -> rx_data_o stays 0x11, one overrun_o pulse, rx_valid_o stays 1.
REQ-041 Assert CS with TX holding empty -> one underrun_o pulse and CIPO=0 for all 8 bits.
REQ-042 Deassert CS after 5 SCK rises -> no rx_valid_o, busy_o=0; next 8-bit frame of 0x5A received intact.
REQ-043 Assert rst_sys_i for 1 cycle after the 3rd SCK rise -> all outputs at reset values next cycle; no rx_valid_o for that frame.
REQ-044 Handshake (rx_ready_i=1) in the same cycle as the next byte completion -> no overrun_o, rx_valid_o stays 1 with the new byte.

Source files
------------

// File: rtl/spi_target.sv
// SPI target (mode 0) with a one-deep TX holding register and a valid/ready RX output.
// All SPI pins are synchronised into clk_sys_i. Edges are detected on the
// synchronised copies, so SCK must run at clk_sys_i/8 or slower.
module spi_target #(
  parameter int DataWidth  = 8,
  parameter int SyncStages = 2
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  input  logic                 spi_cs_ni,
  input  logic                 spi_sck_i,
  input  logic                 spi_copi_i,
  output logic                 spi_cipo_o,
  output logic                 spi_cipo_en_o,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 overrun_o,
  output logic                 underrun_o,
  output logic                 busy_o
);

  localparam int CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SyncStages-1:0] cs_sync, sck_sync, copi_sync;
  logic                  cs_q, sck_q;
  logic                  cs_s, sck_s, copi_s;
  logic [SyncStages:0]   flush;
  logic                  armed;
  logic                  cs_fall, cs_rise, sck_rise, sck_fall;
  logic                  load_now, shift_now, tx_accept;

  state_t                state;
  logic [CntW-1:0]       bit_cnt;
  logic [DataWidth-1:0]  rx_shift, tx_shift, hold_data;
  logic                  hold_full, load_pend, rx_done;

  assign cs_s   = cs_sync[SyncStages-1];
  assign sck_s  = sck_sync[SyncStages-1];
  assign copi_s = copi_sync[SyncStages-1];

  // A cs-fall only counts once armed, so a CS held low across reset cannot start a frame mid-byte.
  assign cs_fall  = armed & cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = ~sck_q & sck_s;
  assign sck_fall = sck_q & ~sck_s;

  assign tx_accept = tx_valid_i & ~hold_full;
  assign tx_ready_o = ~hold_full;

  // A load happens on entering ACTIVE, and on the first SCK fall after a byte completes.
  assign load_now  = ((state == IDLE) && cs_fall) ||
                     ((state == ACTIVE) && !cs_rise && sck_fall && load_pend);
  assign shift_now = (state == ACTIVE) && !cs_rise && sck_fall && !load_pend;

  assign spi_cipo_o    = tx_shift[DataWidth-1];
  assign spi_cipo_en_o = busy_o;

  // Input synchronisers preloaded to the idle bus levels, plus one delayed copy for edge detection.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      copi_sync <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SyncStages-2:0], spi_cs_ni};
      sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
      copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
      cs_q      <= cs_s;
      sck_q     <= sck_s;
    end
  end

  // After reset, wait until the synchronisers hold real samples and CS is seen high before arming.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      flush <= '0;
      armed <= 1'b0;
    end else begin
      flush <= {flush[SyncStages-1:0], 1'b1};
      if (flush[SyncStages] && cs_q && cs_s) armed <= 1'b1;
    end
  end

  // Frame FSM with bit counter, shift registers, TX holding register and RX output handshake.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      load_pend  <= 1'b0;
      rx_done    <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
      rx_done    <= 1'b0;

      if (tx_accept) begin
        hold_full <= 1'b1;
        hold_data <= tx_data_i;
      end

      // A completed byte lands one cycle after the completing SCK rise.
      if (rx_done) begin
        if (rx_valid_o && !rx_ready_i) begin
          overrun_o <= 1'b1;
        end else begin
          rx_data_o  <= rx_shift;
          rx_valid_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            busy_o    <= 1'b1;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            load_pend <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            load_pend <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[DataWidth-2:0], copi_s};
              if (bit_cnt == CntW'(DataWidth - 1)) begin
                bit_cnt   <= '0;
                rx_done   <= 1'b1;
                load_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CntW'(1);
              end
            end
            if (load_now) load_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_now) begin
        if (hold_full) begin
          tx_shift  <= hold_data;
          hold_full <= 1'b0;
        end else begin
          tx_shift   <= '0;
          underrun_o <= 1'b1;
        end
      end else if (shift_now) begin
        tx_shift <= tx_shift << 1;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: SPI controller driven at clk/8, outputs sampled 1 ns after each edge.
module tb_spi_target;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk_sys_i = 1'b0;
  logic          rst_sys_i;
  logic          spi_cs_ni, spi_sck_i, spi_copi_i;
  logic          spi_cipo_o, spi_cipo_en_o;
  logic [DW-1:0] tx_data_i;
  logic          tx_valid_i, tx_ready_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o, rx_ready_i;
  logic          overrun_o, underrun_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int unr_cnt = 0;

  spi_target #(.DataWidth(DW), .SyncStages(SS)) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_sys_i    (rst_sys_i),
    .spi_cs_ni    (spi_cs_ni),
    .spi_sck_i    (spi_sck_i),
    .spi_copi_i   (spi_copi_i),
    .spi_cipo_o   (spi_cipo_o),
    .spi_cipo_en_o(spi_cipo_en_o),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .overrun_o    (overrun_o),
    .underrun_o   (underrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  // Count single-cycle status pulses.
  always @(negedge clk_sys_i) begin
    if (overrun_o)  ovr_cnt <= ovr_cnt + 1;
    if (underrun_o) unr_cnt <= unr_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic c);
    spi_copi_i = b;
    tick(4);
    c = spi_cipo_o;
    spi_sck_i = 1'b1;
    tick(4);
    spi_sck_i = 1'b0;
  endtask

  task automatic send_byte(input logic [DW-1:0] d, output logic [DW-1:0] c);
    logic cb;
    for (int i = DW - 1; i >= 0; i--) begin
      send_bit(d[i], cb);
      c[i] = cb;
    end
  endtask

  task automatic cs_low();
    spi_cs_ni = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_ni = 1'b1;
    tick(8);
  endtask

  task automatic rx_pop();
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},     busy_o, 0);
    chk({tag, "_rxvalid"},  rx_valid_o, 0);
    chk({tag, "_rxdata"},   rx_data_o, 0);
    chk({tag, "_txready"},  tx_ready_o, 1);
    chk({tag, "_cipo"},     spi_cipo_o, 0);
    chk({tag, "_cipo_en"},  spi_cipo_en_o, 0);
    chk({tag, "_overrun"},  overrun_o, 0);
    chk({tag, "_underrun"}, underrun_o, 0);
  endtask

  initial begin
    logic [DW-1:0] cipo_byte;
    logic          cb;
    logic [7:0]    pat;
    int            u0, o0;

    rst_sys_i = 1'b1;
    spi_cs_ni = 1'b1;
    spi_sck_i = 1'b0;
    spi_copi_i = 1'b0;
    tx_data_i = '0;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    tick(3);
    chk_reset_outputs("reset");
    rst_sys_i = 1'b0;
    tick(SS + 4);
    chk("post_reset_busy", busy_o, 0);

    // Basic frame: TX 0xA5, RX 0x3C, with RX latency check on the last bit.
    tx_data_i = 8'hA5;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    chk("hold_full_txready", tx_ready_o, 0);
    cs_low();
    chk("active_busy", busy_o, 1);
    chk("active_cipo_en", spi_cipo_en_o, 1);
    chk("hold_moved_txready", tx_ready_o, 1);
    pat = 8'h3C;
    for (int i = 7; i >= 1; i--) begin
      send_bit(pat[i], cb);
      cipo_byte[i] = cb;
    end
    spi_copi_i = pat[0];
    tick(4);
    cipo_byte[0] = spi_cipo_o;
    spi_sck_i = 1'b1;
    tick(SS + 1);
    chk("latency_not_yet", rx_valid_o, 0);
    tick(1);
    chk("latency_valid", rx_valid_o, 1);
    spi_sck_i = 1'b0;
    chk("cipo_a5", cipo_byte, 8'hA5);
    chk("rx_3c", rx_data_o, 8'h3C);
    cs_high();
    chk("idle_busy", busy_o, 0);
    chk("idle_cipo_en", spi_cipo_en_o, 0);
    chk("idle_cipo", spi_cipo_o, 0);
    rx_pop();
    chk("rx_pop_clear", rx_valid_o, 0);

    // Underrun: frame starts with the holding register empty.
    u0 = unr_cnt;
    cs_low();
    chk("underrun_pulse", unr_cnt - u0, 1);
    send_byte(8'hFF, cipo_byte);
    chk("underrun_cipo_zero", cipo_byte, 0);
    cs_high();
    chk("rx_ff", rx_data_o, 8'hFF);
    rx_pop();

    // Overrun: two bytes without the consumer accepting.
    o0 = ovr_cnt;
    cs_low();
    send_byte(8'h11, cipo_byte);
    send_byte(8'h22, cipo_byte);
    cs_high();
    chk("overrun_rx_kept", rx_data_o, 8'h11);
    chk("overrun_valid", rx_valid_o, 1);
    chk("overrun_pulse", ovr_cnt - o0, 1);
    rx_pop();
    chk("overrun_pop", rx_valid_o, 0);

    // Abort mid-byte, then a clean frame.
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1, cb);
    cs_high();
    chk("abort_no_valid", rx_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    cs_low();
    send_byte(8'h5A, cipo_byte);
    cs_high();
    chk("after_abort_rx", rx_data_o, 8'h5A);
    chk("after_abort_valid", rx_valid_o, 1);
    rx_pop();

    // Reset mid-frame after the 3rd SCK rise.
    tx_data_i = 8'h77;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    cs_low();
    send_bit(1'b1, cb);
    send_bit(1'b0, cb);
    spi_copi_i = 1'b1;
    tick(4);
    spi_sck_i = 1'b1;
    tick(4);
    rst_sys_i = 1'b1;
    tick(1);
    rst_sys_i = 1'b0;
    chk_reset_outputs("midreset");
    spi_sck_i = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, cb);
    tick(4);
    chk("midreset_no_valid", rx_valid_o, 0);
    chk("midreset_wait_cs", busy_o, 0);
    cs_high();
    cs_low();
    send_byte(8'hC3, cipo_byte);
    cs_high();
    chk("rearm_rx", rx_data_o, 8'hC3);
    rx_pop();

    // Handshake in the same cycle as the next completion.
    o0 = ovr_cnt;
    cs_low();
    send_byte(8'h33, cipo_byte);
    chk("hs_first_valid", rx_valid_o, 1);
    pat = 8'h44;
    for (int i = 7; i >= 1; i--) send_bit(pat[i], cb);
    spi_copi_i = pat[0];
    tick(4);
    spi_sck_i = 1'b1;
    tick(SS + 1);
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
    chk("hs_valid", rx_valid_o, 1);
    chk("hs_data", rx_data_o, 8'h44);
    tick(1);
    chk("hs_valid_held", rx_valid_o, 1);
    tick(2);
    spi_sck_i = 1'b0;
    cs_high();
    chk("hs_no_overrun", ovr_cnt - o0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
